quad_gen: RTL

- Quadrature pulse generator: the transmit-side counterpart of the team's rotary-encoder decoder.
- Accepts an 8-bit target count over a valid/ready handshake. Emits a/b quadrature waveforms that drive a downstream decoder from its current count to the target, stepping in the shortest direction.
- Used as an on-chip stimulus source for the RGB mixer inputs and in loopback self-test.

---
 rtl/quad_gen_pkg.sv | 54 +++++
 rtl/quad_gen_step_timer.sv | 28 ++
 rtl/quad_gen.sv | 101 ++++++++++
 3 files changed

// File: rtl/quad_gen_pkg.sv
// Shared definitions for the quadrature pulse generator: phase indices,
// their {a,b} pin encodings, the move state machine states and phase stepping.
package quad_gen_pkg;

  // Phase indices; a forward step is +1 mod 4, a reverse step is -1 mod 4.
  localparam logic [1:0] P0 = 2'd0;
  localparam logic [1:0] P1 = 2'd1;
  localparam logic [1:0] P2 = 2'd2;
  localparam logic [1:0] P3 = 2'd3;

  // {a,b} pin encodings. Adjacent phases differ in exactly one bit.
  localparam logic [1:0] AB_P0 = 2'b00;
  localparam logic [1:0] AB_P1 = 2'b10;
  localparam logic [1:0] AB_P2 = 2'b11;
  localparam logic [1:0] AB_P3 = 2'b01;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEAD  = 2'd1,   // next transition leaves an even phase and moves the count
    TRAIL = 2'd2    // next transition leaves an odd phase, count unchanged
  } state_t;

  typedef enum logic {
    DIR_FWD = 1'b0,
    DIR_REV = 1'b1
  } dir_t;

  // A latched move request.
  typedef struct packed {
    logic [7:0] target;
    dir_t       dir;
  } move_t;

  // One quadrature step. The 2-bit arithmetic gives the mod-4 wrap for free.
  function automatic logic [1:0] next_phase(input logic [1:0] phase, input dir_t dir);
    logic [1:0] np;
    if (dir == DIR_REV) np = phase - 2'd1;
    else                np = phase + 2'd1;
    return np;
  endfunction

  // Phase index to {a,b} pin levels.
  function automatic logic [1:0] phase_ab(input logic [1:0] phase);
    logic [1:0] ab;
    case (phase)
      P0:      ab = AB_P0;
      P1:      ab = AB_P1;
      P2:      ab = AB_P2;
      default: ab = AB_P3;
    endcase
    return ab;
  endfunction

endpackage

// File: rtl/quad_gen_step_timer.sv
// Reloadable prescaler. While running, it counts down to zero, then raises
// tick for one cycle and reloads itself, so tick repeats every STEP_CYCLES
// clocks. A load starts a fresh STEP_CYCLES-long interval.
module step_timer #(
  parameter int unsigned STEP_CYCLES = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic clk,
  input  logic reset,   // async, active low
  input  logic load,
  input  logic run,
  output logic tick
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(STEP_CYCLES - 1);

  logic [CNT_W-1:0] count;

  assign tick = run && (count == '0);

  // Count down while running; reload on an explicit load or on expiry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              count <= '0;
    else if (load || tick)   count <= RELOAD;
    else if (run)            count <= count - CNT_W'(1);
  end

endmodule

// File: rtl/quad_gen.sv
// Quadrature pulse generator. It takes a target count and drives a/b so
// that a downstream x1 decoder walks from its current count to the target
// by the shorter way round. position mirrors what that decoder should read.
module quad_gen
  import quad_gen_pkg::*;
#(
  parameter int unsigned STEP_CYCLES = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic       clk,
  input  logic       reset,       // async, active low
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_target,
  output logic       a,
  output logic       b,
  output logic [7:0] position,
  output logic       busy
);

  state_t     state;
  logic [1:0] phase;
  logic [1:0] nphase;
  move_t      mv;
  logic [7:0] diff;
  logic       accept;
  logic       start;
  logic       tick;

  assign cmd_ready = !busy;
  assign accept    = cmd_valid && cmd_ready;
  // Two's-complement distance. Its sign bit picks the short way round;
  // a distance of exactly 128 has the sign bit set and so goes in reverse.
  assign diff      = cmd_target - position;
  // A target equal to position is consumed without starting a move.
  assign start     = accept && (diff != 8'd0);
  assign nphase    = next_phase(phase, mv.dir);

  step_timer #(
    .STEP_CYCLES (STEP_CYCLES),
    .CNT_W       (CNT_W)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (start),
    .run   (state != IDLE),
    .tick  (tick)
  );

  // Move sequencer. a/b, position and busy are all registered here, so each
  // pin changes cleanly on one edge and only one of a/b moves per step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      phase    <= P0;
      mv       <= '0;
      position <= 8'd0;
      busy     <= 1'b0;
      a        <= 1'b0;
      b        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mv.target <= cmd_target;
            mv.dir    <= diff[7] ? DIR_REV : DIR_FWD;
            busy      <= 1'b1;
            state     <= LEAD;
          end
        end
        LEAD: begin
          if (tick) begin
            phase    <= nphase;
            {a, b}   <= phase_ab(nphase);
            position <= (mv.dir == DIR_REV) ? position - 8'd1 : position + 8'd1;
            state    <= TRAIL;
          end
        end
        TRAIL: begin
          if (tick) begin
            phase  <= nphase;
            {a, b} <= phase_ab(nphase);
            // This step lands on an even phase, so stopping here leaves the
            // decoder settled on the count it has just reached.
            if (position == mv.target) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              state <= LEAD;
            end
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
